// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer slice: FSM state encoding,
// default geometry/level limits and the obstacle-height generator.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PLAY     = 2'd1,
        ST_GAMEOVER = 2'd2,
        ST_WIN      = 2'd3
    } game_state_t;

    localparam int X_WRAP_DEF    = 640;
    localparam int Y_MAX_DEF     = 200;
    localparam int WIN_LEVEL_DEF = 6;

    // Obstacle height sequence: t = 3*y1 + 7, folded back below 100 once it grows too tall
    localparam logic [11:0] LCG_MUL   = 12'd3;
    localparam logic [11:0] LCG_ADD   = 12'd7;
    localparam logic [11:0] LCG_LIMIT = 12'd220;
    localparam logic [11:0] LCG_MOD   = 12'd100;

    // Next obstacle height after a wrap; 12 bits hold 3*1023+7 without overflow
    function automatic logic [9:0] obst_next(input logic [9:0] y1);
        logic [11:0] t;
        t = {2'b00, y1} * LCG_MUL + LCG_ADD;
        if (t >= LCG_LIMIT) begin
            t = t % LCG_MOD;
        end
        return t[9:0];
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame start detector: one registered pulse each time the raster arrives at
// (0,0), no matter how many clocks it lingers there. After reset the origin is
// treated as already seen, so the raster must leave and come back first.
module frame_tick_gen (
    input  logic       clk_d,
    input  logic       rst,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    output logic       frame_tick
);

    logic at_origin;
    logic origin_seen;

    assign at_origin = (pixel_x == 10'd0) && (pixel_y == 10'd0);

    // Rising-edge detect on the origin flag, registered pulse out
    always_ff @(posedge clk_d) begin
        if (rst) begin
            origin_seen <= 1'b1;
            frame_tick  <= 1'b0;
        end else begin
            origin_seen <= at_origin;
            frame_tick  <= at_origin && !origin_seen;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Frame-rate game controller: owns obstacle/player motion, level, score and
// the IDLE/PLAY/GAMEOVER/WIN state; the pixel generator only renders.
// Optional build macro GAME_PAUSE_EN adds a 'pause' input that freezes
// per-frame motion while playing (collisions still end the game).
module game_sequencer
    import game_pkg::*;
#(
    parameter int X_WRAP      = X_WRAP_DEF,
    parameter int SPEED_INIT  = 5,
    parameter int SPEED_MAX   = 15,
    parameter int Y_MAX       = Y_MAX_DEF,
    parameter int Y_STEP      = 3,
    parameter int OBST_Y_INIT = 10,
    parameter int WIN_LEVEL   = WIN_LEVEL_DEF
) (
    input  logic       clk_d,
    input  logic       btn,
`ifdef GAME_PAUSE_EN
    input  logic       pause,
`endif
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       mySW1,
    input  logic       collision,
    output logic [9:0] x_loc,
    output logic [9:0] y_loc,
    output logic [9:0] y1_loc,
    output logic [2:0] level,
    output logic [1:0] game_state,
    output logic [9:0] score,
    output logic       score_stop_signal,
    output logic       win_signal,
    output logic       frame_tick
);

    game_state_t state;
    logic [9:0]  speed;
    logic [10:0] x_sum;
    logic        wrap;
    logic [2:0]  level_nx;
    logic        pause_act;

`ifdef GAME_PAUSE_EN
    assign pause_act = pause;
`else
    assign pause_act = 1'b0;
`endif

    frame_tick_gen u_tick (
        .clk_d      (clk_d),
        .rst        (btn),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .frame_tick (frame_tick)
    );

    // Wrap decision uses an 11-bit sum so x_loc+speed near 1023 cannot alias
    assign x_sum      = {1'b0, x_loc} + {1'b0, speed};
    assign wrap       = (x_sum >= 11'(X_WRAP));
    assign level_nx   = (level == 3'(WIN_LEVEL)) ? level : level + 3'd1;
    assign game_state = state;

    // Rising jump: a step that would pass Y_MAX is skipped, keeping the height on the Y_STEP grid
    function automatic logic [9:0] y_rise(input logic [9:0] y);
        logic [10:0] s;
        s = {1'b0, y} + 11'(Y_STEP);
        return (s > 11'(Y_MAX)) ? y : s[9:0];
    endfunction

    // Falling: clamp at ground level instead of wrapping
    function automatic logic [9:0] y_fall(input logic [9:0] y);
        return (y < 10'(Y_STEP)) ? 10'd0 : y - 10'(Y_STEP);
    endfunction

    // Game FSM plus all per-frame motion; collision outranks any same-cycle frame update
    always_ff @(posedge clk_d) begin
        if (btn) begin
            state             <= ST_IDLE;
            x_loc             <= 10'd0;
            y_loc             <= 10'd0;
            y1_loc            <= 10'(OBST_Y_INIT);
            speed             <= 10'(SPEED_INIT);
            level             <= 3'd0;
            score             <= 10'd0;
            score_stop_signal <= 1'b0;
            win_signal        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_tick && !mySW1) begin
                        state <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (collision) begin
                        state             <= ST_GAMEOVER;
                        score_stop_signal <= 1'b1;
                    end else if (frame_tick && !pause_act) begin
                        if (wrap) begin
                            x_loc  <= 10'd0;
                            level  <= level_nx;
                            score  <= (score == 10'd1023) ? score : score + 10'd1;
                            speed  <= (speed >= 10'(SPEED_MAX)) ? speed : speed + 10'd1;
                            y1_loc <= obst_next(y1_loc);
                            if (level_nx == 3'(WIN_LEVEL)) begin
                                state             <= ST_WIN;
                                win_signal        <= 1'b1;
                                score_stop_signal <= 1'b1;
                            end
                        end else begin
                            x_loc <= x_sum[9:0];
                        end
                        y_loc <= mySW1 ? y_rise(y_loc) : y_fall(y_loc);
                    end
                end
                default: begin
                    // GAMEOVER and WIN hold everything until reset
                end
            endcase
        end
    end

endmodule
